// File: rtl/background_control_pipeline.sv
// -----------------------------------------------------------------------------
// background_control_pipeline
//
// One background layer's fetch/render pipeline. It works bit-serially over a
// scan line. A line is 36 slots of 8 clocks each. In slot s the tile-map
// address for column (s + pan) mod 32 is shifted out. In slot s+1 the
// character number and palette select come back. In slot s+2 the pattern
// address (the character number) is shifted out. In slot s+3 both bit-planes
// come back. In slot s+4 the eight pixels of the tile are streamed.
// Each stage has its own registers, so four tiles overlap in flight.
//
// Ports
//   clk              system clock, all state on the rising edge
//   reset_n          asynchronous active-low reset
//   lineStarting     one-cycle pulse that starts or restarts a line
//   panOffset[4:0]   coarse pan in tiles, latched with lineStarting
//   charAddrOut      serial tile-map address, MSB first
//   palAddrOut       serial palette-map address (same value as charAddrOut)
//   charDataIn       serial character number, MSB first
//   palDataIn        palette select, only sampled in phase 0
//   tileLowAddrOut   serial low-plane pattern address, MSB first
//   tileHighAddrOut  serial high-plane pattern address (same value)
//   tileLowDataIn    serial low-plane byte, MSB = leftmost pixel
//   tileHighDataIn   serial high-plane byte, MSB = leftmost pixel
//   pixelOut         serial pixel stream, one pixel per clock
// -----------------------------------------------------------------------------
module background_control_pipeline #(
  parameter int TILES      = 32,
  parameter int PIPE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       lineStarting,
  input  logic [4:0] panOffset,
  output logic       charAddrOut,
  input  logic       charDataIn,
  output logic       palAddrOut,
  input  logic       palDataIn,
  output logic       tileLowAddrOut,
  output logic       tileHighAddrOut,
  input  logic       tileLowDataIn,
  input  logic       tileHighDataIn,
  output logic       pixelOut
);

  // Slot windows in which each stage holds a tile.
  localparam logic [5:0] LAST_SLOT  = 6'(TILES + PIPE_DEPTH - 1);
  localparam logic [5:0] MAP_LAST   = 6'(TILES - 1);
  localparam logic [5:0] CHAR_FIRST = 6'd1;
  localparam logic [5:0] CHAR_LAST  = 6'(TILES);
  localparam logic [5:0] TADR_FIRST = 6'd2;
  localparam logic [5:0] TADR_LAST  = 6'(TILES + 1);
  localparam logic [5:0] PAT_FIRST  = 6'd3;
  localparam logic [5:0] PAT_LAST   = 6'(TILES + 2);
  localparam logic [5:0] PIX_FIRST  = 6'(PIPE_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] slot_q, slot_d;
  logic [2:0] phase_q, phase_d;
  logic [4:0] pan_q, pan_d;

  // Stage 1: character number and palette select arriving.
  logic [7:0] char_sh_q, char_sh_d;
  logic       pal1_q, pal1_d;
  // Stage 2: pattern address going out.
  logic [7:0] char_num_q, char_num_d;
  logic       pal2_q, pal2_d;
  // Stage 3: bit-planes arriving.
  logic [7:0] low_sh_q, low_sh_d;
  logic [7:0] high_sh_q, high_sh_d;
  logic       pal3_q, pal3_d;
  // Stage 4: pixels going out.
  logic [7:0] low_pat_q, low_pat_d;
  logic [7:0] high_pat_q, high_pat_d;
  logic       pal4_q, pal4_d;

  // Registered serial outputs. Each pair of address ports carries the same
  // address, so one flop drives both ports of the pair.
  logic       map_addr_q, map_addr_d;
  logic       tile_addr_q, tile_addr_d;
  logic       pixel_q, pixel_d;

  // Output-side helpers, computed from the next-state values.
  logic       run;
  logic       slot_end;
  logic       run_next;
  logic [2:0] bit_sel;
  logic [4:0] col_next;
  logic [7:0] map_byte;

  always_comb begin
    // NOTE: every signal written here gets a default first. Without a
    // default, a path that does not assign a signal would infer a latch.
    state_d     = state_q;
    slot_d      = slot_q;
    phase_d     = phase_q;
    pan_d       = pan_q;
    char_sh_d   = char_sh_q;
    pal1_d      = pal1_q;
    char_num_d  = char_num_q;
    pal2_d      = pal2_q;
    low_sh_d    = low_sh_q;
    high_sh_d   = high_sh_q;
    pal3_d      = pal3_q;
    low_pat_d   = low_pat_q;
    high_pat_d  = high_pat_q;
    pal4_d      = pal4_q;
    map_addr_d  = 1'b0;
    tile_addr_d = 1'b0;
    pixel_d     = 1'b0;

    run      = (state_q == ST_RUN);
    slot_end = (phase_q == 3'd7);

    if (lineStarting) begin
      // A restart wins over the counter advance and drops any tiles in flight.
      state_d    = ST_RUN;
      slot_d     = 6'd0;
      phase_d    = 3'd0;
      pan_d      = panOffset;
      char_sh_d  = 8'd0;
      pal1_d     = 1'b0;
      char_num_d = 8'd0;
      pal2_d     = 1'b0;
      low_sh_d   = 8'd0;
      high_sh_d  = 8'd0;
      pal3_d     = 1'b0;
      low_pat_d  = 8'd0;
      high_pat_d = 8'd0;
      pal4_d     = 1'b0;
    end else if (run) begin
      // Capture stages sample inputs in the slot they currently occupy.
      if (slot_q >= CHAR_FIRST && slot_q <= CHAR_LAST) begin
        char_sh_d = {char_sh_q[6:0], charDataIn};
        if (phase_q == 3'd0) pal1_d = palDataIn;
      end
      if (slot_q >= PAT_FIRST && slot_q <= PAT_LAST) begin
        low_sh_d  = {low_sh_q[6:0], tileLowDataIn};
        high_sh_d = {high_sh_q[6:0], tileHighDataIn};
      end

      // At a slot boundary every tile moves on by one stage. The completed
      // shift values include the bit sampled on this same edge.
      if (slot_end) begin
        char_num_d = char_sh_d;
        pal2_d     = pal1_d;
        pal3_d     = pal2_q;
        low_pat_d  = low_sh_d;
        high_pat_d = high_sh_d;
        pal4_d     = pal3_q;
      end

      phase_d = phase_q + 3'd1;
      if (slot_end) begin
        if (slot_q == LAST_SLOT) begin
          state_d = ST_IDLE;
          slot_d  = 6'd0;
        end else begin
          slot_d = slot_q + 6'd1;
        end
      end
    end

    // The outputs are registered. They are computed from the next-state
    // values so that the bit for (slot, phase) is visible in that cycle.
    run_next = (state_d == ST_RUN);
    bit_sel  = 3'd7 - phase_d;
    col_next = slot_d[4:0] + pan_d;
    map_byte = {3'b000, col_next};

    if (run_next) begin
      if (slot_d <= MAP_LAST) map_addr_d = map_byte[bit_sel];
      if (slot_d >= TADR_FIRST && slot_d <= TADR_LAST) tile_addr_d = char_num_d[bit_sel];
      if (slot_d >= PIX_FIRST && slot_d <= LAST_SLOT)
        pixel_d = pal4_d ? high_pat_d[bit_sel] : low_pat_d[bit_sel];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. This way
  // every flop samples values from before the edge, whatever the order of
  // the statements.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      slot_q      <= 6'd0;
      phase_q     <= 3'd0;
      pan_q       <= 5'd0;
      char_sh_q   <= 8'd0;
      pal1_q      <= 1'b0;
      char_num_q  <= 8'd0;
      pal2_q      <= 1'b0;
      low_sh_q    <= 8'd0;
      high_sh_q   <= 8'd0;
      pal3_q      <= 1'b0;
      low_pat_q   <= 8'd0;
      high_pat_q  <= 8'd0;
      pal4_q      <= 1'b0;
      map_addr_q  <= 1'b0;
      tile_addr_q <= 1'b0;
      pixel_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      phase_q     <= phase_d;
      pan_q       <= pan_d;
      char_sh_q   <= char_sh_d;
      pal1_q      <= pal1_d;
      char_num_q  <= char_num_d;
      pal2_q      <= pal2_d;
      low_sh_q    <= low_sh_d;
      high_sh_q   <= high_sh_d;
      pal3_q      <= pal3_d;
      low_pat_q   <= low_pat_d;
      high_pat_q  <= high_pat_d;
      pal4_q      <= pal4_d;
      map_addr_q  <= map_addr_d;
      tile_addr_q <= tile_addr_d;
      pixel_q     <= pixel_d;
    end
  end

  assign charAddrOut     = map_addr_q;
  assign palAddrOut      = map_addr_q;
  assign tileLowAddrOut  = tile_addr_q;
  assign tileHighAddrOut = tile_addr_q;
  assign pixelOut        = pixel_q;

endmodule

// File: tb/tb_background_control_pipeline.sv
// -----------------------------------------------------------------------------
// tb_background_control_pipeline
//
// The bench drives whole scan lines. A memory responder listens to the serial
// address outputs and answers from four random memories in the data slots.
// Every cycle, all outputs are compared against a reference. The reference
// derives the expected bits directly from the line rules: the column for each
// slot, then the tile-map lookup, then the pattern lookup. A table of
// hand-picked tiles checks the slot-0/31 address bytes, the slot-2 pattern
// address and the slot-4 pixel byte. Two hand-written sequences cover a
// mid-line restart and an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_background_control_pipeline;

  logic       clk;
  logic       reset_n;
  logic       lineStarting;
  logic [4:0] panOffset;
  logic       charAddrOut, charDataIn;
  logic       palAddrOut, palDataIn;
  logic       tileLowAddrOut, tileHighAddrOut;
  logic       tileLowDataIn, tileHighDataIn;
  logic       pixelOut;

  background_control_pipeline dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .lineStarting    (lineStarting),
    .panOffset       (panOffset),
    .charAddrOut     (charAddrOut),
    .charDataIn      (charDataIn),
    .palAddrOut      (palAddrOut),
    .palDataIn       (palDataIn),
    .tileLowAddrOut  (tileLowAddrOut),
    .tileHighAddrOut (tileHighAddrOut),
    .tileLowDataIn   (tileLowDataIn),
    .tileHighDataIn  (tileHighDataIn),
    .pixelOut        (pixelOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Memories seen by the responder and by the reference.
  logic [7:0] char_mem [256];
  logic       pal_mem  [256];
  logic [7:0] low_mem  [256];
  logic [7:0] high_mem [256];

  // Bytes observed during the last line, used by the table checks.
  logic [7:0] got_char0, got_pal0, got_char31, got_tile2, got_pix4;

  typedef struct {
    int         pan;
    logic [7:0] chr;
    logic       pal;
    logic [7:0] low;
    logic [7:0] high;
    logic [7:0] exp_addr0;
    logic [7:0] exp_addr31;
    logic [7:0] exp_tile2;
    logic [7:0] exp_pix4;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {charAddrOut, palAddrOut, tileLowAddrOut, tileHighAddrOut, pixelOut};
  endfunction

  // Expected {charAddr, palAddr, tileLowAddr, tileHighAddr, pixel} in cycle
  // T+k of a line started with the given pan.
  function automatic logic [4:0] exp_bits(input int k, input int pan);
    int         s, p, col;
    logic [7:0] a, c, pat;
    logic       m, t, x;
    m = 1'b0; t = 1'b0; x = 1'b0;
    if (k >= 1 && k <= 288) begin
      s = (k - 1) / 8;
      p = (k - 1) % 8;
      if (s < 32) begin
        a = 8'((s + pan) % 32);
        m = a[7-p];
      end
      if (s >= 2 && s <= 33) begin
        c = char_mem[(s - 2 + pan) % 32];
        t = c[7-p];
      end
      if (s >= 4 && s <= 35) begin
        col = (s - 4 + pan) % 32;
        c   = char_mem[col];
        pat = pal_mem[col] ? high_mem[c] : low_mem[c];
        x   = pat[7-p];
      end
    end
    return {m, m, t, t, x};
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) begin
      char_mem[i] = 8'($urandom);
      pal_mem[i]  = 1'($urandom);
      low_mem[i]  = 8'($urandom);
      high_mem[i] = 8'($urandom);
    end
  endtask

  // Pulse lineStarting with the given pan, then run n cycles of the line.
  // Each cycle: compare outputs, capture serial addresses, answer from memory.
  // The task is entered and left at a falling edge.
  task automatic run_line(input int pan, input int n);
    logic [7:0] cap_c, cap_p, cap_l, cap_h, cap_x;
    logic [7:0] lat_c, lat_p, lat_l, lat_h, tmp;
    int s, p;
    cap_c = 0; cap_p = 0; cap_l = 0; cap_h = 0; cap_x = 0;
    lat_c = 0; lat_p = 0; lat_l = 0; lat_h = 0;
    lineStarting = 1'b1;
    panOffset    = 5'(pan);
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      lineStarting = 1'b0;
      panOffset    = 5'($urandom);   // mid-line pan changes must be ignored
      s = (k - 1) / 8;
      p = (k - 1) % 8;
      check($sformatf("line pan=%0d cyc=T+%0d outs", pan, k), 32'(outs()), 32'(exp_bits(k, pan)));
      cap_c = {cap_c[6:0], charAddrOut};
      cap_p = {cap_p[6:0], palAddrOut};
      cap_l = {cap_l[6:0], tileLowAddrOut};
      cap_h = {cap_h[6:0], tileHighAddrOut};
      cap_x = {cap_x[6:0], pixelOut};
      // Data sampled by the DUT on the edge that ends this cycle.
      tmp = char_mem[lat_c];
      charDataIn     = (s >= 1 && s <= 32) ? tmp[7-p] : 1'($urandom);
      palDataIn      = (s >= 1 && s <= 32 && p == 0) ? pal_mem[lat_p] : 1'($urandom);
      tmp = low_mem[lat_l];
      tileLowDataIn  = (s >= 3 && s <= 34) ? tmp[7-p] : 1'($urandom);
      tmp = high_mem[lat_h];
      tileHighDataIn = (s >= 3 && s <= 34) ? tmp[7-p] : 1'($urandom);
      if (p == 7) begin
        lat_c = cap_c; lat_p = cap_p; lat_l = cap_l; lat_h = cap_h;
        if (s == 0) begin got_char0 = cap_c; got_pal0 = cap_p; end
        if (s == 31) got_char31 = cap_c;
        if (s == 2)  got_tile2  = cap_l;
        if (s == 4)  got_pix4   = cap_x;
      end
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      panOffset      = 5'($urandom);
      charDataIn     = 1'($urandom);
      palDataIn      = 1'($urandom);
      tileLowDataIn  = 1'($urandom);
      tileHighDataIn = 1'($urandom);
      check(name, 32'(outs()), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{pan: 0,  chr: 8'hA5, pal: 1'b0, low: 8'hC3, high: 8'h00,
                exp_addr0: 8'h00, exp_addr31: 8'h1F, exp_tile2: 8'hA5, exp_pix4: 8'hC3};
    vecs[1] = '{pan: 30, chr: 8'h3C, pal: 1'b1, low: 8'hFF, high: 8'h0F,
                exp_addr0: 8'h1E, exp_addr31: 8'h1D, exp_tile2: 8'h3C, exp_pix4: 8'h0F};
    vecs[2] = '{pan: 31, chr: 8'hFF, pal: 1'b0, low: 8'h81, high: 8'h7E,
                exp_addr0: 8'h1F, exp_addr31: 8'h1E, exp_tile2: 8'hFF, exp_pix4: 8'h81};
    vecs[3] = '{pan: 5,  chr: 8'h00, pal: 1'b1, low: 8'h55, high: 8'hAA,
                exp_addr0: 8'h05, exp_addr31: 8'h04, exp_tile2: 8'h00, exp_pix4: 8'hAA};

    reset_n = 1'b0; lineStarting = 1'b0; panOffset = 5'd0;
    charDataIn = 1'b0; palDataIn = 1'b0; tileLowDataIn = 1'b0; tileHighDataIn = 1'b0;
    fill_mem();

    // Reset, then idle without lineStarting.
    repeat (3) @(negedge clk);
    check("reset_state", 32'(outs()), 32'd0);
    reset_n = 1'b1;
    idle_cycles("idle_after_reset", 400);

    // Asynchronous reset in mid-line: the map address bit is 1 here (col 9, bit 0).
    fill_mem();
    run_line(3, 56);
    check("pre_reset_map_addr", 32'(charAddrOut), 32'd1);
    #1 reset_n = 1'b0;
    #1 check("async_reset_outs", 32'(outs()), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle_cycles("idle_after_midline_reset", 40);

    // Table-driven tiles placed at the column of slot 0.
    for (int v = 0; v < 4; v++) begin
      logic [7:0] ch;
      fill_mem();
      ch = vecs[v].chr;
      char_mem[vecs[v].pan] = ch;
      pal_mem[vecs[v].pan]  = vecs[v].pal;
      low_mem[ch]           = vecs[v].low;
      high_mem[ch]          = vecs[v].high;
      run_line(vecs[v].pan, 300);
      check($sformatf("vec%0d char_addr_slot0", v),  32'(got_char0),  32'(vecs[v].exp_addr0));
      check($sformatf("vec%0d pal_addr_slot0", v),   32'(got_pal0),   32'(vecs[v].exp_addr0));
      check($sformatf("vec%0d char_addr_slot31", v), 32'(got_char31), 32'(vecs[v].exp_addr31));
      check($sformatf("vec%0d tile_addr_slot2", v),  32'(got_tile2),  32'(vecs[v].exp_tile2));
      check($sformatf("vec%0d pixels_slot4", v),     32'(got_pix4),   32'(vecs[v].exp_pix4));
    end

    // Random lines with random pans.
    for (int r = 0; r < 6; r++) begin
      fill_mem();
      run_line(int'($urandom_range(0, 31)), 300);
    end

    // Restart in slot 10 with a new pan; the old line is abandoned.
    fill_mem();
    run_line(7, 84);
    run_line(30, 300);
    idle_cycles("idle_after_restart_line", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
